mux_serial_sequencer: RTL and testbench
=======================================

// Module: mux_serial_sequencer
// PURPOSE
//   Upstream controller for mux8x1 used as an 8:1 parallel-to-serial converter.
//   On start, steps mux8x1 select 0..7 (in_a first = LSB) at one bit per DIV clocks.
//   Frames the mux output on tx: start bit (0), 8 data bits, optional parity, stop bit (1).
//   Drives select/enable of the mux and consumes its out; tx feeds the board serial line.
// PARAMETERS
//   DIV      16   clock cycles per serial bit; legal range DIV >= 2
//   CNT_W    $clog2(DIV)   width of the bit-timer count (derived, do not override)
// PORTS
//   clk         in   1  system clock, all state updates on rising edge
//   reset       in   1  synchronous, active-high reset
//   start       in   1  request a frame; sampled only in IDLE
//   mux_out     in   1  out of mux8x1 (combinational, same-cycle)
//   select      out  3  to mux8x1 select; current data-bit index
//   mux_enable  out  1  to mux8x1 enable; 1 only in DATA
//   tx          out  1  serial line, idle high
//   busy        out  1  1 from the cycle after start is accepted until the end of STOP
//   done        out  1  one-cycle pulse on the last cycle of STOP
// BEHAVIOUR
//   Reset values: state=IDLE, select=0, mux_enable=0, tx=1, busy=0, done=0, cnt=0.
//   States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: tx=1. start=1 -> START next cycle, cnt=0. Other inputs ignored.
//   Bit timer: cnt counts 0..DIV-1 in every non-IDLE state. bit_end = (cnt==DIV-1).
//     It wraps to 0 at bit_end.
//   START: tx=0 for DIV cycles; on bit_end -> DATA, select=0.
//   DATA: mux_enable=1. tx = mux_out (combinational pass-through, no extra register).
//     On bit_end: if select==7 -> PARITY or STOP, else select+1.
//     select stays 7 after the last bit until IDLE, then returns to 0.
//   STOP: tx=1 for DIV cycles; done=1 on bit_end; -> IDLE.
//   Frame length: 10*DIV cycles (11*DIV with parity). busy is high for exactly that many cycles.
//   start while busy (including the done cycle) is ignored, not queued.
//     A start on the cycle after done is accepted.
//   reset mid-frame: next cycle IDLE, tx=1, busy=0, no done pulse.
//   mux_out is sampled only while mux_enable=1; any value outside DATA has no effect.
// CONFIGURATION
//   Macro MUX_SERIAL_PARITY_EN.
//   Defined: even-parity register p, cleared in START.
//     p ^= mux_out on each DATA bit_end.
//     PARITY state drives tx=p for DIV cycles, then -> STOP. Frame is 11*DIV cycles.
//   Undefined: no PARITY state and no p register. DATA goes directly to STOP. Frame is 10*DIV cycles.
// STRUCTURE
//   Package mux_serial_pkg: state encoding constants
//     (S_IDLE, S_START, S_DATA, S_PARITY, S_STOP; 3 bits), DIV default, IDLE_LEVEL=1.
//   Sub-module bit_timer: CNT_W counter with clear input; outputs bit_end.
//   FSM, select register and parity remain in this module.
// TESTING
//   DIV=4. Mux inputs hold 0xA5. Pulse start.
//     -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
//     -> busy high 40 cycles; done pulses on cycle 40.
//   During the frame, select walks 0..7, changing every 4 cycles; mux_enable=1 for exactly 32 cycles.
//   Hold start=1 continuously.
//     -> frames start on the cycle after each done.
//     -> no frame is lost or truncated; no second frame starts mid-frame.
//   Assert reset at cycle 13 of a frame.
//     -> next cycle tx=1, busy=0, select=0, mux_enable=0; no done pulse.
//   MUX_SERIAL_PARITY_EN, data 0x07.
//     -> parity bit = 1, frame 44 cycles.
//   MUX_SERIAL_PARITY_EN, data 0x03.
//     -> parity bit = 0.
//   DIV=2, data 0xFF and 0x00.
//     -> correct minimal-rate frames; tx is never X during any state.

Source files
------------

// File: rtl/mux_serial_pkg.sv
// Shared state encoding and defaults for the mux8x1 serial sequencer.
package mux_serial_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    localparam int         DIV_DEFAULT = 16;
    localparam logic       IDLE_LEVEL  = 1'b1;
    localparam logic [2:0] LAST_SEL    = 3'd7;

endpackage

// File: rtl/mux_serial_sequencer_bit_timer.sv
// Bit timer: counts 0..DIV-1 while enabled, held at 0 by clear; flags the last cycle of a bit.
module bit_timer #(
    parameter  int DIV   = 16,
    localparam int CNT_W = $clog2(DIV)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || bit_end) begin
            cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_serial_sequencer.sv
// Steps mux8x1 select 0..7 and frames its output on tx as start/data/[parity]/stop.
// Define MUX_SERIAL_PARITY_EN to add an even-parity bit after the data bits.
module mux_serial_sequencer
    import mux_serial_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mux_out,
    output logic [2:0] select,
    output logic       mux_enable,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    state_e     state_q, state_d;
    logic [2:0] select_q, select_d;
    logic       bit_end;
    logic       timer_clear;

`ifdef MUX_SERIAL_PARITY_EN
    logic parity_q, parity_d;
`endif

    assign timer_clear = (state_q == S_IDLE);

    bit_timer #(.DIV(DIV)) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .bit_end (bit_end)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        select_d   = select_q;
        tx         = IDLE_LEVEL;
        mux_enable = 1'b0;
        done       = 1'b0;
`ifdef MUX_SERIAL_PARITY_EN
        parity_d   = parity_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_START;
            end
            S_START: begin
                tx = 1'b0;
`ifdef MUX_SERIAL_PARITY_EN
                parity_d = 1'b0;
`endif
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                mux_enable = 1'b1;
                tx         = mux_out;
                if (bit_end) begin
`ifdef MUX_SERIAL_PARITY_EN
                    parity_d = parity_q ^ mux_out;
`endif
                    if (select_q == LAST_SEL) begin
`ifdef MUX_SERIAL_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        select_d = select_q + 3'd1;
                    end
                end
            end
`ifdef MUX_SERIAL_PARITY_EN
            S_PARITY: begin
                tx = parity_q;
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                done = bit_end;
                if (bit_end) begin
                    state_d  = S_IDLE;
                    select_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            select_q <= '0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
        end
    end

`ifdef MUX_SERIAL_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign select = select_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_mux_serial_sequencer.sv
// Self-checking bench: two sequencers (DIV=4 and DIV=2) driven by a behavioural mux model.
module tb_mux_serial_sequencer;

    localparam int N    = 2;
    localparam int DIV0 = 4;
    localparam int DIV1 = 2;
`ifdef MUX_SERIAL_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef struct {
        logic [7:0] data;
        logic       exp_parity;
    } vec_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start      [N];
    logic       mux_out    [N];
    logic [2:0] select     [N];
    logic       mux_enable [N];
    logic       tx         [N];
    logic       busy       [N];
    logic       done       [N];
    logic [7:0] data       [N];
    logic       noise      [N];
    int         pos        [N];
    int         n_checks = 0;
    int         n_errors = 0;
    bit         chk_en   = 1'b0;
    vec_t       vecs [6];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mux_serial_sequencer #(.DIV(g == 0 ? DIV0 : DIV1)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start[g]),
            .mux_out    (mux_out[g]),
            .select     (select[g]),
            .mux_enable (mux_enable[g]),
            .tx         (tx[g]),
            .busy       (busy[g]),
            .done       (done[g])
        );
        // Behavioural mux8x1: outside DATA the line carries noise the sequencer must ignore.
        assign mux_out[g] = mux_enable[g] ? data[g][select[g]] : noise[g];
    end

    function automatic int div_of(input int i);
        return (i == 0) ? DIV0 : DIV1;
    endfunction

    function automatic int flen(input int i);
        return FRAME_BITS * div_of(i);
    endfunction

    // Expected line level at frame position p (negative = idle).
    function automatic logic exp_tx(input int i, input int p);
        int b;
        if (p < 0) return 1'b1;
        b = p / div_of(i);
        if (b == 0) return 1'b0;
        if (b <= 8) return data[i][b-1];
`ifdef MUX_SERIAL_PARITY_EN
        if (b == 9) return ^data[i];
`endif
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame-level reference: position within the current frame, advanced once per clock.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) pos[i] = -1;
            else if (pos[i] < 0) begin
                if (start[i]) pos[i] = 0;
            end else if (pos[i] == flen(i) - 1) pos[i] = -1;
            else pos[i] = pos[i] + 1;
        end
    end

    always @(negedge clk) begin : model_check
        int p, b;
        logic [2:0] e_sel;
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                p = pos[i];
                b = (p < 0) ? -1 : p / div_of(i);
                e_sel = (b >= 1 && b <= 8) ? 3'(b - 1) : ((b > 8) ? 3'd7 : 3'd0);
                check($sformatf("tx[%0d] pos %0d", i, p), 32'(tx[i]), 32'(exp_tx(i, p)));
                check($sformatf("busy[%0d] pos %0d", i, p), 32'(busy[i]), 32'(p >= 0));
                check($sformatf("done[%0d] pos %0d", i, p), 32'(done[i]), 32'(p == flen(i) - 1));
                check($sformatf("mux_enable[%0d] pos %0d", i, p), 32'(mux_enable[i]),
                      32'(b >= 1 && b <= 8));
                check($sformatf("select[%0d] pos %0d", i, p), 32'(select[i]), 32'(e_sel));
            end
        end
        foreach (noise[i]) noise[i] = 1'($urandom);
    end

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (busy[i] !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check($sformatf("idle_wait[%0d]", i), 32'(busy[i]), 32'd0);
    endtask

    task automatic run_frame(input int i, input vec_t v);
        int d, fl, busy_cnt, en_cnt, done_cnt, done_at;
        logic [10:0] fw;
        d = div_of(i);
        fl = flen(i);
        busy_cnt = 0; en_cnt = 0; done_cnt = 0; done_at = -1;
`ifdef MUX_SERIAL_PARITY_EN
        fw = {1'b1, v.exp_parity, v.data, 1'b0};
`else
        fw = {2'b11, v.data, 1'b0};
`endif
        wait_idle(i);
        data[i]  = v.data;
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
        for (int c = 0; c < fl + 2 * d; c++) begin
            @(negedge clk);
            if (busy[i] === 1'b1) busy_cnt++;
            if (mux_enable[i] === 1'b1) en_cnt++;
            if (done[i] === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            if (c < fl && (c % d) == d / 2)
                check($sformatf("vec %02h inst %0d bit %0d", v.data, i, c / d),
                      32'(tx[i]), 32'(fw[c/d]));
        end
        check($sformatf("vec %02h inst %0d busy_len", v.data, i), busy_cnt, fl);
        check($sformatf("vec %02h inst %0d enable_len", v.data, i), en_cnt, 8 * d);
        check($sformatf("vec %02h inst %0d done_cnt", v.data, i), done_cnt, 1);
        check($sformatf("vec %02h inst %0d done_at", v.data, i), done_at, fl - 1);
    endtask

    initial begin
        int fl;
        int done_cyc [$];
        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h03, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h00, 1'b0};
        vecs[5] = '{8'h01, 1'b1};
        for (int i = 0; i < N; i++) begin
            start[i] = 1'b0;
            data[i]  = 8'h00;
            noise[i] = 1'b0;
            pos[i]   = -1;
        end

        reset = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < N; i++) begin
            check($sformatf("reset tx[%0d]", i), 32'(tx[i]), 32'd1);
            check($sformatf("reset busy[%0d]", i), 32'(busy[i]), 32'd0);
            check($sformatf("reset done[%0d]", i), 32'(done[i]), 32'd0);
            check($sformatf("reset select[%0d]", i), 32'(select[i]), 32'd0);
            check($sformatf("reset mux_enable[%0d]", i), 32'(mux_enable[i]), 32'd0);
        end
        reset  = 1'b0;
        chk_en = 1'b1;
        tick();

        for (int k = 0; k < 6; k++)
            for (int i = 0; i < N; i++)
                run_frame(i, vecs[k]);

        // Start held high: back-to-back frames separated by a single idle cycle.
        wait_idle(0);
        fl = flen(0);
        data[0]  = 8'hA5;
        start[0] = 1'b1;
        tick();
        for (int c = 0; c < 3 * (fl + 1); c++) begin
            @(negedge clk);
            if (done[0] === 1'b1) done_cyc.push_back(c);
        end
        start[0] = 1'b0;
        check("held_start done_count", done_cyc.size(), 3);
        for (int m = 0; m < done_cyc.size() && m < 3; m++)
            check($sformatf("held_start done %0d", m), done_cyc[m], fl - 1 + m * (fl + 1));
        tick();
        wait_idle(0);

        // Reset asserted during cycle 13 of a frame.
        data[0]  = 8'hA5;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (13) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset tx", 32'(tx[0]), 32'd1);
        check("midreset busy", 32'(busy[0]), 32'd0);
        check("midreset select", 32'(select[0]), 32'd0);
        check("midreset mux_enable", 32'(mux_enable[0]), 32'd0);
        check("midreset done", 32'(done[0]), 32'd0);
        begin
            int dn;
            dn = 0;
            for (int c = 0; c < fl; c++) begin
                @(negedge clk);
                if (done[0] !== 1'b0) dn++;
            end
            check("midreset no_done", dn, 0);
        end
        tick();

        // Random traffic: sporadic starts (also while busy), new data between frames, rare resets.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (pos[i] < 0) data[i] = 8'($urandom);
                start[i] = ($urandom_range(0, 5) == 0);
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        for (int i = 0; i < N; i++) start[i] = 1'b0;
        tick();
        for (int i = 0; i < N; i++) wait_idle(i);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
